// File: rtl/counting_arbiter_if.sv
// Channel-side bundle for counting_arbiter: symbol requests from the sources,
// the symbol/answer pair of the shared detector, and per-channel grant/hit.
interface counting_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] sym;
    logic [N_REQ-1:0]   last;
    logic [N_REQ-1:0]   grant;
    logic [1:0]         num;
    logic               ans_in;
    logic [N_REQ-1:0]   hit;

    // Symbol sources and detector.
    modport master (
        output req, sym, last, ans_in,
        input  grant, num, hit
    );

    // The arbiter.
    modport slave (
        input  req, sym, last, ans_in,
        output grant, num, hit
    );
endinterface

// File: rtl/counting_arbiter.sv
// Round-robin burst arbiter sharing one counting detector among N_REQ sources;
// flushes the detector between bursts and routes each ans pulse back to its source.
module counting_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int ANS_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    counting_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] owner;
    } tag_t;

    state_t           state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [N_REQ-1:0] grant_q;
    logic [1:0]       num_q;
    tag_t             num_tag;
    tag_t             tail;

    logic             pick_found;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic [1:0]       sym_g;
    logic             req_g;
    logic             last_g;
    logic [N_REQ-1:0] hit_c;

    // First requester at or after rr_ptr, wrapping.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k >= N_REQ) ? ID_W'(int'(rr_ptr) + k - N_REQ)
                                               : ID_W'(int'(rr_ptr) + k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign next_ptr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign sym_g    = bus.sym[{owner, 1'b0} +: 2];
    assign req_g    = bus.req[owner];
    assign last_g   = bus.last[owner];

    // NOTE: all state here updates with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FLUSH;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_q   <= '0;
            num_q     <= '0;
            num_tag   <= '0;
        end else begin
            num_tag <= '0;
            case (state)
                FLUSH: begin
                    num_q   <= '0;
                    grant_q <= '0;
                    state   <= IDLE;
                end

                IDLE: begin
                    num_q <= '0;
                    if (pick_found) begin
                        owner     <= pick;
                        grant_q   <= N_REQ'(1) << pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end

                BURST: begin
                    if (req_g) begin
                        num_q     <= sym_g;
                        num_tag   <= {1'b1, owner};
                        burst_cnt <= burst_cnt + 1'b1;
                        if (last_g || burst_cnt == CNT_LAST) begin
                            grant_q <= '0;
                            rr_ptr  <= next_ptr;
                            state   <= FLUSH;
                        end
                    end else begin
                        // Hole: the zero on num also flushes the detector.
                        num_q   <= '0;
                        grant_q <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= FLUSH;
                    end
                end

                default: begin
                    num_q   <= '0;
                    grant_q <= '0;
                    state   <= FLUSH;
                end
            endcase
        end
    end

    // Owner tags follow num through the detector latency so late answers still
    // reach the channel whose symbol produced them, even after the burst ended.
    generate
        if (ANS_LAT == 0) begin : g_direct
            assign tail = num_tag;
        end else begin : g_pipe
            tag_t pipe [ANS_LAT];

            // NOTE: the tag pipeline is reset so stale tags cannot credit a hit after reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < ANS_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= num_tag;
                    for (int i = 1; i < ANS_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign tail = pipe[ANS_LAT-1];
        end
    endgenerate

    always_comb begin
        hit_c = '0;
        if (bus.ans_in && tail.valid) hit_c[tail.owner] = 1'b1;
    end

    assign bus.grant = grant_q;
    assign bus.num   = num_q;
    assign bus.hit   = hit_c;
endmodule

// File: tb/tb_counting_arbiter.sv
// Scoreboard bench for counting_arbiter: directed bursts with hand-computed
// expected num/grant/hit streams, checked by a separate monitor process.
`timescale 1ns/1ps
module tb_counting_arbiter;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 16;
    localparam int ANS_LAT   = 1;
    localparam int TIMEOUT   = 200;

    typedef struct packed {
        logic       last;
        logic [1:0] sym;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic det_en = 1'b0;
    logic ans_force = 1'b0;

    int checks = 0;
    int errors = 0;

    item_t            src_q [N_REQ][$];
    logic [1:0]       exp_num_q [$];
    logic [N_REQ-1:0] exp_grant_q [$];
    logic [N_REQ-1:0] exp_hit_q [$];

    always #5 clk = ~clk;

    counting_arbiter_if #(.N_REQ(N_REQ)) bus ();

    counting_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_BURST(MAX_BURST),
        .ANS_LAT  (ANS_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [1:0] s, input logic l, input logic expect_out);
        src_q[ch].push_back({l, s});
        if (expect_out) exp_num_q.push_back(s);
    endtask

    // Sources: present the queue head; pop it when grant&req was seen before the edge.
    initial begin : driver
        logic [N_REQ-1:0] fire;
        item_t            it;
        bus.req  = '0;
        bus.sym  = '0;
        bus.last = '0;
        forever begin
            @(negedge clk);
            fire = bus.grant & bus.req;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    it = src_q[i][0];
                    bus.req[i]        = 1'b1;
                    bus.sym[2*i +: 2] = it.sym;
                    bus.last[i]       = it.last;
                end else begin
                    bus.req[i]        = 1'b0;
                    bus.sym[2*i +: 2] = 2'd0;
                    bus.last[i]       = 1'b0;
                end
            end
        end
    end

    // Detector model: answers one cycle after num shows 3 (ANS_LAT = 1).
    initial begin : detector
        logic n3;
        bus.ans_in = 1'b0;
        forever begin
            @(negedge clk);
            n3 = det_en && (bus.num == 2'd3);
            @(posedge clk);
            #1;
            bus.ans_in = n3 || ans_force;
        end
    end

    initial begin : monitor
        logic [N_REQ-1:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (bus.num != 2'd0) begin
                if (exp_num_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL num_unexpected: actual=%0d expected none at %0t", bus.num, $time);
                end else begin
                    check("num_order", 32'(bus.num), 32'(exp_num_q.pop_front()));
                end
            end
            check("grant_onehot", {31'b0, $onehot0(bus.grant)}, 32'd1);
            if (bus.grant != '0 && bus.grant != prev_grant) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: actual=%b expected none at %0t", bus.grant, $time);
                end else begin
                    check("grant_order", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
                end
            end
            prev_grant = bus.grant;
            if (bus.ans_in === 1'b1) begin
                if (exp_hit_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ans_unexpected: hit=%b expected none at %0t", bus.hit, $time);
                end else begin
                    check("hit_attrib", 32'(bus.hit), 32'(exp_hit_q.pop_front()));
                end
            end else begin
                check("hit_quiet", 32'(bus.hit), 32'd0);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_num", 32'(bus.num), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input logic [N_REQ-1:0] g, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.grant !== g && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.grant), 32'(g));
    endtask

    task automatic wait_num(input logic [1:0] v, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.num !== v && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.num), 32'(v));
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((exp_num_q.size() != 0 || exp_grant_q.size() != 0 || exp_hit_q.size() != 0)
               && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({name, "_num_drained"}, 32'(exp_num_q.size()), 32'd0);
        check({name, "_grant_drained"}, 32'(exp_grant_q.size()), 32'd0);
        check({name, "_hit_drained"}, 32'(exp_hit_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:0]       t1_num [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [N_REQ-1:0] t1_gnt [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [N_REQ-1:0] t2_gnt [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100};
        int hi;
        int lo;

        // 1: single ch0 burst 1,1,2,3,3 with cycle-exact num from the grant cycle
        apply_reset();
        push(0, 2'd1, 1'b0, 1'b1);
        push(0, 2'd1, 1'b0, 1'b1);
        push(0, 2'd2, 1'b0, 1'b1);
        push(0, 2'd3, 1'b0, 1'b1);
        push(0, 2'd3, 1'b1, 1'b1);
        exp_grant_q.push_back(4'b0001);
        wait_grant(4'b0001, "t1_grant");
        check("t1_num_0", 32'(bus.num), 32'(t1_num[0]));
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            check("t1_num_seq", 32'(bus.num), 32'(t1_num[k]));
            check("t1_grant_seq", 32'(bus.grant), 32'(t1_gnt[k]));
        end
        settle("t1");

        // 1b: rr_ptr moved to 1, so ch1 beats ch0 when both request
        push(1, 2'd1, 1'b1, 1'b1);
        push(0, 2'd2, 1'b1, 1'b1);
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0001);
        settle("t1b");

        // 2: ch0 and ch2 together from reset; ch0 first, two-cycle gap, then ch2
        apply_reset();
        push(0, 2'd1, 1'b0, 1'b1);
        push(0, 2'd2, 1'b1, 1'b1);
        push(2, 2'd3, 1'b0, 1'b1);
        push(2, 2'd3, 1'b1, 1'b1);
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0100);
        wait_grant(4'b0001, "t2_grant0");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_grant_seq", 32'(bus.grant), 32'(t2_gnt[k]));
        end
        settle("t2");

        // 3: ch1 streams 20 symbols without last; watchdog cuts at 16, then regrant
        apply_reset();
        for (int k = 0; k < 20; k++) push(1, 2'((k % 3) + 1), 1'b0, 1'b1);
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0010);
        wait_grant(4'b0010, "t3_grant");
        hi = 1;
        @(negedge clk);
        while (bus.grant == 4'b0010 && hi < TIMEOUT) begin
            hi++;
            @(negedge clk);
        end
        check("t3_burst1_cycles", 32'(hi), 32'd16);
        lo = 0;
        while (bus.grant == 4'b0000 && lo < TIMEOUT) begin
            lo++;
            @(negedge clk);
        end
        check("t3_gap_cycles", 32'(lo), 32'd2);
        hi = 0;
        while (bus.grant == 4'b0010 && hi < TIMEOUT) begin
            hi++;
            @(negedge clk);
        end
        check("t3_burst2_cycles", 32'(hi), 32'd5);
        settle("t3");

        // 4: ch3 burst 1,2,3; the answer after 3 credits ch3 only
        apply_reset();
        det_en = 1'b1;
        push(3, 2'd1, 1'b0, 1'b1);
        push(3, 2'd2, 1'b0, 1'b1);
        push(3, 2'd3, 1'b1, 1'b1);
        exp_grant_q.push_back(4'b1000);
        exp_hit_q.push_back(4'b1000);
        settle("t4");
        det_en = 1'b0;
        // stray answer with no tagged symbol in flight is dropped
        @(negedge clk);
        ans_force = 1'b1;
        exp_hit_q.push_back(4'b0000);
        @(negedge clk);
        ans_force = 1'b0;
        settle("t4_stray");

        // 5: ch0 drops req after 1,2; hole, FLUSH, IDLE, then ch1
        apply_reset();
        push(0, 2'd1, 1'b0, 1'b1);
        push(0, 2'd2, 1'b0, 1'b1);
        push(1, 2'd2, 1'b0, 1'b1);
        push(1, 2'd1, 1'b1, 1'b1);
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        wait_num(2'd2, "t5_num2");
        @(negedge clk);
        check("t5_hole_num", 32'(bus.num), 32'd0);
        check("t5_hole_grant", 32'(bus.grant), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_next_grant", 32'(bus.grant), 32'b0010);
        settle("t5");

        // 6: reset mid-burst with an answer pending; the late answer is dropped
        apply_reset();
        det_en = 1'b1;
        push(0, 2'd1, 1'b0, 1'b1);
        push(0, 2'd2, 1'b0, 1'b1);
        push(0, 2'd3, 1'b0, 1'b1);
        push(0, 2'd2, 1'b0, 1'b0);
        push(0, 2'd2, 1'b1, 1'b0);
        exp_grant_q.push_back(4'b0001);
        wait_num(2'd3, "t6_num3");
        reset = 1'b1;
        src_q[0].delete();
        exp_hit_q.push_back(4'b0000);
        @(negedge clk);
        check("t6_grant", 32'(bus.grant), 32'd0);
        check("t6_num", 32'(bus.num), 32'd0);
        check("t6_hit", 32'(bus.hit), 32'd0);
        reset = 1'b0;
        det_en = 1'b0;
        settle("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
